avaliador_ativos_minimos: RTL and testbench

- Active-node table that feeds localizador_vizinhos_validos.
- Holds up to NUM_NA frontier nodes, each with address, tentative distance and predecessor.
- On request, scans the table and flags every node at the minimum distance as "aprovado".
- Consumes the neighbour stage's atualizar (insert/relax) and desativar (remove) pulses; raises ocupado while it works.

---
 rtl/avaliador_ativos_minimos_if.sv | 38 +++
 rtl/avaliador_ativos_minimos.sv | 233 +++++++++++++++++++++++
 tb/tb_avaliador_ativos_minimos.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avaliador_ativos_minimos_if.sv
// Request/response bundle between the neighbour stage and the active-node table.
//   master : drives the avaliar/atualizar/desativar pulses and operands, observes table state
//   slave  : the active-node table (avaliador_ativos_minimos)
interface avaliador_ativos_minimos_if #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int NUM_NA          = 4
);
  logic                              cme_avaliar_in;
  logic                              lvv_atualizar_in;
  logic [ADDR_WIDTH-1:0]             lvv_endereco_in;
  logic [DISTANCIA_WIDTH-1:0]        lvv_distancia_in;
  logic [ADDR_WIDTH-1:0]             lvv_anterior_in;
  logic                              lvv_desativar_in;
  logic [ADDR_WIDTH-1:0]             lvv_desativar_addr_in;
  logic                              aa_ocupado_out;
  logic                              aa_pronto_out;
  logic [NUM_NA-1:0]                 aa_aprovado_out;
  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_out;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out;
  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_out;
  logic                              aa_vazio_out;
  logic                              aa_overflow_out;

  modport master (
    output cme_avaliar_in, lvv_atualizar_in, lvv_endereco_in, lvv_distancia_in,
           lvv_anterior_in, lvv_desativar_in, lvv_desativar_addr_in,
    input  aa_ocupado_out, aa_pronto_out, aa_aprovado_out, aa_endereco_out,
           aa_distancia_out, aa_anterior_data_out, aa_vazio_out, aa_overflow_out
  );

  modport slave (
    input  cme_avaliar_in, lvv_atualizar_in, lvv_endereco_in, lvv_distancia_in,
           lvv_anterior_in, lvv_desativar_in, lvv_desativar_addr_in,
    output aa_ocupado_out, aa_pronto_out, aa_aprovado_out, aa_endereco_out,
           aa_distancia_out, aa_anterior_data_out, aa_vazio_out, aa_overflow_out
  );
endinterface

// File: rtl/avaliador_ativos_minimos.sv
// Active-node table: holds up to NUM_NA frontier nodes (address, distance,
// predecessor), applies insert/relax and remove requests, and on request flags
// every valid node at the minimum distance as aprovado.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of avaliador_ativos_minimos_if (request pulses in,
//                table contents / aprovado mask / status out)
//
// state       | meaning
// ST_IDLE     | pick highest-priority pending request (desativar > atualizar > avaliar)
// ST_BUSCAR   | compare operand address against valid slots, find first free slot
// ST_ESCREVER | apply remove / relax / insert, then back to idle
// ST_MINIMO   | walk slots, track minimum distance among valid ones
// ST_MARCAR   | walk slots, mark those equal to the minimum
// ST_PRONTO   | one-cycle pronto pulse
module avaliador_ativos_minimos #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int NUM_NA          = 4,
  parameter int IDX_WIDTH       = $clog2(NUM_NA)
) (
  input logic clk,
  input logic rst_n,
  avaliador_ativos_minimos_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_BUSCAR, ST_ESCREVER, ST_MINIMO, ST_MARCAR, ST_PRONTO
  } state_t;

  state_t state_q, state_d;

  logic                       pend_desativar, pend_atualizar, pend_avaliar;
  logic [ADDR_WIDTH-1:0]      des_addr_q;
  logic [ADDR_WIDTH-1:0]      atu_addr_q, atu_ant_q;
  logic [DISTANCIA_WIDTH-1:0] atu_dist_q;
  logic                       take_des, take_atu, take_ava;

  // operands of the operation in flight, decoupled from new pulses
  logic                       op_atu_q;
  logic [ADDR_WIDTH-1:0]      op_addr_q, op_ant_q;
  logic [DISTANCIA_WIDTH-1:0] op_dist_q;

  logic                       hit_c, free_c, hit_q, full_q;
  logic [IDX_WIDTH-1:0]       hit_idx_c, free_idx_c, hit_idx_q, free_idx_q;

  logic [IDX_WIDTH-1:0]       cnt_q;
  logic                       cnt_last;
  logic [DISTANCIA_WIDTH-1:0] min_q;
  logic                       any_valid_q;

  logic [NUM_NA-1:0]          valid_q, aprovado_q;
  logic [ADDR_WIDTH-1:0]      addr_q [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] dist_q [NUM_NA];
  logic [ADDR_WIDTH-1:0]      ant_q  [NUM_NA];
  logic                       overflow_q;

  assign cnt_last = (cnt_q == IDX_WIDTH'(NUM_NA - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take_des = 1'b0;
    take_atu = 1'b0;
    take_ava = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_desativar) begin
          take_des = 1'b1;
          state_d  = ST_BUSCAR;
        end else if (pend_atualizar) begin
          take_atu = 1'b1;
          state_d  = ST_BUSCAR;
        end else if (pend_avaliar) begin
          take_ava = 1'b1;
          state_d  = ST_MINIMO;
        end
      end
      ST_BUSCAR:   state_d = ST_ESCREVER;
      ST_ESCREVER: state_d = ST_IDLE;
      ST_MINIMO:   if (cnt_last) state_d = ST_MARCAR;
      ST_MARCAR:   if (cnt_last) state_d = ST_PRONTO;
      ST_PRONTO:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // a pulse in the same cycle its flag is taken wins, so it is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_desativar <= 1'b0;
      pend_atualizar <= 1'b0;
      pend_avaliar   <= 1'b0;
      des_addr_q     <= '0;
      atu_addr_q     <= '0;
      atu_dist_q     <= '0;
      atu_ant_q      <= '0;
    end else begin
      if (bus.lvv_desativar_in) begin
        pend_desativar <= 1'b1;
        des_addr_q     <= bus.lvv_desativar_addr_in;
      end else if (take_des) begin
        pend_desativar <= 1'b0;
      end
      if (bus.lvv_atualizar_in) begin
        pend_atualizar <= 1'b1;
        atu_addr_q     <= bus.lvv_endereco_in;
        atu_dist_q     <= bus.lvv_distancia_in;
        atu_ant_q      <= bus.lvv_anterior_in;
      end else if (take_atu) begin
        pend_atualizar <= 1'b0;
      end
      if (bus.cme_avaliar_in)  pend_avaliar <= 1'b1;
      else if (take_ava)       pend_avaliar <= 1'b0;
    end
  end

  // descending scan so the lowest matching / free index wins
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int k = NUM_NA - 1; k >= 0; k--) begin
      if (valid_q[k] && (addr_q[k] == op_addr_q)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_WIDTH'(k);
      end
      if (!valid_q[k]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_atu_q    <= 1'b0;
      op_addr_q   <= '0;
      op_dist_q   <= '0;
      op_ant_q    <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      free_idx_q  <= '0;
      full_q      <= 1'b0;
      cnt_q       <= '0;
      min_q       <= '1;
      any_valid_q <= 1'b0;
      valid_q     <= '0;
      aprovado_q  <= '0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < NUM_NA; k++) begin
        addr_q[k] <= '0;
        dist_q[k] <= '0;
        ant_q[k]  <= '0;
      end
    end else begin
      if (take_des) begin
        op_atu_q  <= 1'b0;
        op_addr_q <= des_addr_q;
      end else if (take_atu) begin
        op_atu_q  <= 1'b1;
        op_addr_q <= atu_addr_q;
        op_dist_q <= atu_dist_q;
        op_ant_q  <= atu_ant_q;
      end else if (take_ava) begin
        cnt_q       <= '0;
        min_q       <= '1;
        any_valid_q <= 1'b0;
      end

      case (state_q)
        ST_BUSCAR: begin
          hit_q      <= hit_c;
          hit_idx_q  <= hit_idx_c;
          free_idx_q <= free_idx_c;
          full_q     <= ~free_c;
        end
        ST_ESCREVER: begin
          if (op_addr_q != '1) begin
            if (!op_atu_q) begin
              if (hit_q) begin
                valid_q[hit_idx_q]    <= 1'b0;
                aprovado_q[hit_idx_q] <= 1'b0;
              end
            end else if (hit_q) begin
              if (op_dist_q < dist_q[hit_idx_q]) begin
                dist_q[hit_idx_q] <= op_dist_q;
                ant_q[hit_idx_q]  <= op_ant_q;
              end
            end else if (full_q) begin
              overflow_q <= 1'b1;
            end else begin
              addr_q[free_idx_q]  <= op_addr_q;
              dist_q[free_idx_q]  <= op_dist_q;
              ant_q[free_idx_q]   <= op_ant_q;
              valid_q[free_idx_q] <= 1'b1;
            end
          end
        end
        ST_MINIMO: begin
          if (valid_q[cnt_q]) begin
            any_valid_q <= 1'b1;
            if (dist_q[cnt_q] < min_q) min_q <= dist_q[cnt_q];
          end
          cnt_q <= cnt_last ? '0 : cnt_q + IDX_WIDTH'(1);
          if (cnt_last) aprovado_q <= '0;
        end
        ST_MARCAR: begin
          aprovado_q[cnt_q] <= any_valid_q && valid_q[cnt_q] && (dist_q[cnt_q] == min_q);
          cnt_q <= cnt_last ? '0 : cnt_q + IDX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.aa_ocupado_out  = (state_q != ST_IDLE) || pend_desativar || pend_atualizar || pend_avaliar;
  assign bus.aa_pronto_out   = (state_q == ST_PRONTO);
  assign bus.aa_aprovado_out = aprovado_q;
  assign bus.aa_vazio_out    = ~|valid_q;
  assign bus.aa_overflow_out = overflow_q;

  for (genvar g = 0; g < NUM_NA; g++) begin : g_pack
    assign bus.aa_endereco_out[ADDR_WIDTH*g +: ADDR_WIDTH]                = addr_q[g];
    assign bus.aa_distancia_out[DISTANCIA_WIDTH*g +: DISTANCIA_WIDTH]     = dist_q[g];
    assign bus.aa_anterior_data_out[ADDR_WIDTH*g +: ADDR_WIDTH]           = ant_q[g];
  end

endmodule

// File: tb/tb_avaliador_ativos_minimos.sv
module tb_avaliador_ativos_minimos;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avaliador_ativos_minimos_if #(.ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .NUM_NA(NA)) bus ();

  avaliador_ativos_minimos #(.ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .NUM_NA(NA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // operation-level reference model
  logic [NA-1:0] m_valid, m_aprov;
  logic [AW-1:0] m_addr [NA];
  logic [DW-1:0] m_dist [NA];
  logic [AW-1:0] m_ant  [NA];
  logic          m_ovf;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = '0;
    m_aprov = '0;
    m_ovf   = 1'b0;
    for (int i = 0; i < NA; i++) begin
      m_addr[i] = '0;
      m_dist[i] = '0;
      m_ant[i]  = '0;
    end
  endtask

  task automatic m_desativar(input logic [AW-1:0] a);
    if (a == {AW{1'b1}}) return;
    for (int i = 0; i < NA; i++)
      if (m_valid[i] && m_addr[i] == a) begin
        m_valid[i] = 1'b0;
        m_aprov[i] = 1'b0;
        return;
      end
  endtask

  task automatic m_atualizar(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] p);
    if (a == {AW{1'b1}}) return;
    for (int i = 0; i < NA; i++)
      if (m_valid[i] && m_addr[i] == a) begin
        if (d < m_dist[i]) begin
          m_dist[i] = d;
          m_ant[i]  = p;
        end
        return;
      end
    for (int i = 0; i < NA; i++)
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1;
        m_addr[i]  = a;
        m_dist[i]  = d;
        m_ant[i]   = p;
        return;
      end
    m_ovf = 1'b1;
  endtask

  task automatic m_avaliar();
    int mn;
    mn = 1 << DW;
    for (int i = 0; i < NA; i++)
      if (m_valid[i] && int'(m_dist[i]) < mn) mn = int'(m_dist[i]);
    for (int i = 0; i < NA; i++)
      m_aprov[i] = m_valid[i] && (int'(m_dist[i]) == mn);
  endtask

  task automatic conferir(input string ctx);
    logic [AW*NA-1:0] e_end, e_ant;
    logic [DW*NA-1:0] e_dist;
    for (int i = 0; i < NA; i++) begin
      e_end[AW*i +: AW]  = m_addr[i];
      e_ant[AW*i +: AW]  = m_ant[i];
      e_dist[DW*i +: DW] = m_dist[i];
    end
    check_val({ctx, " aprovado"},  64'(bus.aa_aprovado_out), 64'(m_aprov));
    check_val({ctx, " vazio"},     64'(bus.aa_vazio_out), 64'(m_valid == '0));
    check_val({ctx, " overflow"},  64'(bus.aa_overflow_out), 64'(m_ovf));
    check_val({ctx, " endereco"},  64'(bus.aa_endereco_out), 64'(e_end));
    check_val({ctx, " distancia"}, 64'(bus.aa_distancia_out), 64'(e_dist));
    check_val({ctx, " anterior"},  64'(bus.aa_anterior_data_out), 64'(e_ant));
  endtask

  task automatic idle_inputs();
    bus.cme_avaliar_in        = 1'b0;
    bus.lvv_atualizar_in      = 1'b0;
    bus.lvv_endereco_in       = '0;
    bus.lvv_distancia_in      = '0;
    bus.lvv_anterior_in       = '0;
    bus.lvv_desativar_in      = 1'b0;
    bus.lvv_desativar_addr_in = '0;
  endtask

  task automatic aplicar_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    conferir("reset");
    check_val("reset ocupado", 64'(bus.aa_ocupado_out), 64'd0);
    check_val("reset pronto",  64'(bus.aa_pronto_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ava_at: -1 no avaliar, k >= 0 pulse at the k-th negedge after the first
  task automatic executar(input bit des, input logic [AW-1:0] daddr,
                          input bit atu, input logic [AW-1:0] aaddr,
                          input logic [DW-1:0] ad, input logic [AW-1:0] aant,
                          input int ava_at,
                          output int busy, output int pronto_k, output int pronto_n);
    int  k;
    bit  done;
    busy = 0; pronto_k = -1; pronto_n = 0;
    @(negedge clk);
    bus.lvv_desativar_in      = des;
    bus.lvv_desativar_addr_in = daddr;
    bus.lvv_atualizar_in      = atu;
    bus.lvv_endereco_in       = aaddr;
    bus.lvv_distancia_in      = ad;
    bus.lvv_anterior_in       = aant;
    bus.cme_avaliar_in        = (ava_at == 0);
    k = 0; done = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      bus.lvv_desativar_in = 1'b0;
      bus.lvv_atualizar_in = 1'b0;
      bus.cme_avaliar_in   = (ava_at == k);
      if (bus.aa_pronto_out) begin
        pronto_n++;
        if (pronto_k < 0) pronto_k = k;
      end
      if (bus.aa_ocupado_out) busy++;
      else if (ava_at < k) done = 1'b1;
    end
    idle_inputs();
    if (!done) check_val("executar timeout", 64'd0, 64'd1);
    if (des) m_desativar(daddr);
    if (atu) m_atualizar(aaddr, ad, aant);
    if (ava_at >= 0) m_avaliar();
  endtask

  task automatic atu(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] p, input string tag);
    int b, pk, pn;
    executar(1'b0, '0, 1'b1, a, d, p, -1, b, pk, pn);
    check_val({tag, " busy"}, 64'(b), 64'd3);
    conferir(tag);
  endtask

  task automatic des(input logic [AW-1:0] a, input string tag);
    int b, pk, pn;
    executar(1'b1, a, 1'b0, '0, '0, '0, -1, b, pk, pn);
    check_val({tag, " busy"}, 64'(b), 64'd3);
    conferir(tag);
  endtask

  task automatic ava(input string tag);
    int b, pk, pn;
    executar(1'b0, '0, 1'b0, '0, '0, '0, 0, b, pk, pn);
    check_val({tag, " pronto latency"}, 64'(pk), 64'(2*NA + 2));
    check_val({tag, " pronto count"}, 64'(pn), 64'd1);
    conferir(tag);
  endtask

  initial begin
    int b, pk, pn;
    idle_inputs();
    m_reset();
    aplicar_reset();

    // inserts
    atu(10'd5, 6'd10, 10'd0, "ins5");
    atu(10'd7, 6'd3, 10'd0, "ins7");
    atu(10'd9, 6'd3, 10'd0, "ins9");
    ava("ava1");
    check_val("ava1 mask", 64'(bus.aa_aprovado_out), 64'h6);

    // relaxation
    atu(10'd5, 6'd2, 10'd1, "relax");
    atu(10'd5, 6'd8, 10'd2, "norelax");
    ava("ava2");
    check_val("ava2 mask", 64'(bus.aa_aprovado_out), 64'h1);

    // remove present / absent, reserved address ignored
    des(10'd7, "des7");
    des(10'd20, "des20");
    atu({AW{1'b1}}, 6'd0, 10'd0, "ins_invalid");

    // fill and overflow
    atu(10'd11, 6'd5, 10'd4, "ins11");
    atu(10'd13, 6'd6, 10'd4, "ins13");
    atu(10'd30, 6'd7, 10'd4, "ovf");
    check_val("ovf flag", 64'(bus.aa_overflow_out), 64'd1);
    des(10'd9, "des9");
    atu(10'd30, 6'd1, 10'd8, "ins30");
    ava("ava3");
    check_val("ava3 mask", 64'(bus.aa_aprovado_out), 64'h4);

    // simultaneous desativar + atualizar of the same address
    executar(1'b1, 10'd5, 1'b1, 10'd5, 6'd4, 10'd3, -1, b, pk, pn);
    check_val("sim busy", 64'(b), 64'd6);
    conferir("sim");
    // avaliar arriving while busy
    executar(1'b1, 10'd11, 1'b1, 10'd40, 6'd0, 10'd2, 2, b, pk, pn);
    check_val("sim_ava pronto count", 64'(pn), 64'd1);
    check_val("sim_ava busy", 64'(b), 64'(6 + 2*NA + 2));
    conferir("sim_ava");

    // reset in the middle of the minimum scan
    @(negedge clk);
    bus.cme_avaliar_in = 1'b1;
    @(negedge clk);
    bus.cme_avaliar_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    conferir("midrst");
    check_val("midrst ocupado", 64'(bus.aa_ocupado_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("midrst pronto", 64'(bus.aa_pronto_out), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2*NA + 4; i++) begin
      @(negedge clk);
      check_val("postrst pronto", 64'(bus.aa_pronto_out), 64'd0);
    end
    ava("ava_empty");

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      bit rd, ra, rv;
      logic [AW-1:0] da, aa, ap;
      logic [DW-1:0] dd;
      if (it % 60 == 59) aplicar_reset();
      rd = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 3) == 0);
      if (!rd && !ra && !rv) ra = 1'b1;
      da = ($urandom_range(0, 15) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 7));
      aa = ($urandom_range(0, 15) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 7));
      dd = DW'($urandom_range(0, 63));
      ap = AW'($urandom_range(0, 1023));
      executar(rd, da, ra, aa, dd, ap, rv ? 0 : -1, b, pk, pn);
      check_val("rnd busy", 64'(b), 64'(3*int'(rd) + 3*int'(ra) + (rv ? 2*NA + 2 : 0)));
      check_val("rnd pronto count", 64'(pn), 64'(rv));
      if (rv) check_val("rnd pronto latency", 64'(pk), 64'(3*int'(rd) + 3*int'(ra) + 2*NA + 2));
      conferir("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
